// File: rtl/coproc_pkg.sv
// Types and sizing helpers shared by the UART frame packer and the coprocessor.
package coproc_pkg;

  localparam int WIDTH_DIN_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_e;

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

  // Idle-timer width; a disabled (0) or 1-cycle timeout still needs one bit.
  function automatic int timer_width(input int cycles);
    if (cycles < 2) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/uart_frame_packer_idle_timer.sv
// Counts idle cycles inside a partial frame; expire holds while the count equals limit.
module idle_timer
  import coproc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int TW = timer_width(TIMEOUT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] limit,
  output logic          expire
);

  logic [TW-1:0] count_q;

  // Saturates at limit so a held expire never wraps back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != limit)) begin
      count_q <= count_q + TW'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expire = 1'b0;
    end else begin : g_enabled
      assign expire = (count_q == limit);
    end
  endgenerate

endmodule

// File: rtl/uart_frame_packer.sv
// Packs UART bytes MSB-first into WIDTH_DIN-bit words; stalled partial frames are dropped.
module uart_frame_packer
  import coproc_pkg::*;
#(
  parameter int WIDTH_DIN      = WIDTH_DIN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [WIDTH_DIN-1:0] din,
  output logic                 din_valid,
  output logic                 frame_timeout,
  output logic                 busy
);

  localparam int NBYTES = nbytes(WIDTH_DIN);
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = timer_width(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
  localparam logic [TW-1:0] LIMIT    = TW'(TIMEOUT_CYCLES);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH_DIN-1:0] sr_q, sr_d;
  logic [WIDTH_DIN-1:0] din_q, din_d;
  logic                 din_valid_q, din_valid_d;
  logic                 frame_timeout_q, frame_timeout_d;
  logic                 busy_q, busy_d;
  logic                 accept;
  logic                 tmr_clear, tmr_enable, tmr_expire;

  assign tmr_clear  = accept || (state_q != COLLECT);
  assign tmr_enable = (state_q == COLLECT) && !rx_valid;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .limit  (LIMIT),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // A byte in EMIT starts the next frame, so back-to-back frames lose nothing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, EMIT: begin
        if (rx_valid) begin
          accept  = 1'b1;
          state_d = COLLECT;
          cnt_d   = CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          accept = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = EMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (tmr_expire) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    sr_d = accept ? {sr_q[WIDTH_DIN-9:0], rx_data} : sr_q;
  end

  always_comb begin
    din_d           = (state_d == EMIT) ? sr_d : din_q;
    din_valid_d     = (state_d == EMIT);
    frame_timeout_d = (state_q == COLLECT) && !rx_valid && tmr_expire;
    busy_d          = (state_d == COLLECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q           <= '0;
      din_valid_q     <= 1'b0;
      frame_timeout_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      din_q           <= din_d;
      din_valid_q     <= din_valid_d;
      frame_timeout_q <= frame_timeout_d;
      busy_q          <= busy_d;
    end
  end

  assign din           = din_q;
  assign din_valid     = din_valid_q;
  assign frame_timeout = frame_timeout_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Scoreboard bench: byte-stream model predicts words and timeouts, a monitor checks DUT pulses.
module tb_uart_frame_packer;

  localparam int W  = 128;
  localparam int T  = 10;
  localparam int NB = W / 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic [W-1:0] din;
  logic         din_valid, frame_timeout, busy;

  always #5 clk = ~clk;

  uart_frame_packer #(
    .WIDTH_DIN(W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .din           (din),
    .din_valid     (din_valid),
    .frame_timeout (frame_timeout),
    .busy          (busy)
  );

  typedef struct {
    bit           is_word;
    logic [W-1:0] word;
    int           cycle;
  } exp_t;

  exp_t         sbq[$];
  logic [7:0]   frame[$];
  int           last_edge = 0;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] mdin = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack_frame();
    logic [W-1:0] w = '0;
    foreach (frame[i]) w = (w << 8) | W'(frame[i]);
    return w;
  endfunction

  // One clock of stimulus; the model decides what the edge about to happen must produce.
  task automatic step(input bit v, input logic [7:0] d);
    int e;
    rx_valid = v;
    rx_data  = d;
    e = cyc + 1;
    if (v) begin
      frame.push_back(d);
      last_edge = e;
      if (frame.size() == NB) begin
        sbq.push_back('{1'b1, pack_frame(), e});
        frame.delete();
      end
    end else if (frame.size() > 0 && e == last_edge + T + 1) begin
      sbq.push_back('{1'b0, '0, e});
      frame.delete();
    end
    @(posedge clk);
    #1 check("busy", W'(busy), W'(frame.size() > 0));
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    rx_valid = 1'b0;
    frame.delete();
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_din", din, '0);
      check("rst_din_valid", W'(din_valid), '0);
      check("rst_frame_timeout", W'(frame_timeout), '0);
      check("rst_busy", W'(busy), '0);
      mdin = '0;
    end else if (din_valid || frame_timeout) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: din_valid=%0b frame_timeout=%0b at cycle %0d, expected no pulse",
                 din_valid, frame_timeout, cyc);
      end else begin
        e = sbq.pop_front();
        check("pulse_din_valid", W'(din_valid), W'(e.is_word));
        check("pulse_frame_timeout", W'(frame_timeout), W'(!e.is_word));
        check("pulse_cycle", W'(cyc), W'(e.cycle));
        if (e.is_word) mdin = e.word;
        check("din", din, mdin);
      end
    end else begin
      check("din_hold", din, mdin);
    end
  end

  initial begin
    int g;
    rst = 1'b1;
    #200 rst = 1'b0;
    @(posedge clk);
    #2;
    idle(20);

    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i < 15) ? 8'hFF : 8'hCE);
      if (i < 15) idle(3);
    end
    idle(5);

    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++)
        step(1'b1, (i < 15) ? 8'h00 : (f == 0 ? 8'h32 : 8'h05));
    idle(5);

    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
    idle(T + 5);
    for (int i = 0; i < 16; i++) step(1'b1, (i < 15) ? 8'h00 : 8'h65);
    idle(3);

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i * 17 + 3));
      if (i >= 3 && i < 15) idle(T);
    end
    idle(T + 5);

    for (int i = 0; i < 8; i++) step(1'b1, 8'hA0 + 8'(i));
    do_reset(3);
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i));
    idle(5);

    for (int n = 0; n < 400; n++) begin
      step(1'b1, 8'($urandom));
      g = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(T - 1, T + 2));
      idle(g);
    end
    idle(2 * T + 5);

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected pulses never seen, required 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
